elevator_call_scheduler: RTL

//  Collects floor calls (-1,1,2,3) and drives the car controller's 3-bit destination bus one call at a time.

---
 rtl/elevator_call_scheduler.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - SCAN-ordered floor call scheduler driving a car destination bus
// Optional feature macro: PARK_EN (send the idle car to PARK_FLOOR after PARK_CYCLES idle cycles).
module elevator_call_scheduler #(
  parameter int unsigned ACK_TIMEOUT = 32'd1000,
  parameter logic [1:0]  PARK_FLOOR  = 2'b01,
  parameter int unsigned PARK_CYCLES = 32'd500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] call_req,
  input  logic [1:0] car_floor,
  input  logic       car_busy,
  output logic [2:0] dest,
  output logic [3:0] pending,
  output logic [1:0] sweep_dir,
  output logic [3:0] served,
  output logic       ack_timeout,
  output logic       sched_busy
);

  typedef enum logic [1:0] {IDLE, SELECT, WAIT_ACK, TRAVEL} state_t;

  localparam logic [2:0] DEST_NONE = 3'b100;

  state_t      state_q;
  logic [3:0]  pending_q;
  logic [3:0]  served_q;
  logic [2:0]  dest_q;
  logic [1:0]  tgt_q;
  logic [1:0]  sweep_dir_q;
  logic        sweep_up_q;
  logic [31:0] ack_cnt_q;
  logic        ack_timeout_q;
  logic        sched_busy_q;

  logic [3:0]  above_mask;
  logic [3:0]  below_mask;
  logic        up_found;
  logic        dn_found;
  logic [1:0]  up_fl;
  logic [1:0]  dn_fl;
  logic [1:0]  sel_fl;
  logic        sel_up;
  logic        here_hit;
  logic        ack_expire;
  logic        arrived;
  logic        park_active;
  logic [3:0]  clr_mask;

  // Calls strictly above / below the car, from the latched lamp state
  assign above_mask = pending_q & (4'b1110 << car_floor);
  assign below_mask = pending_q & ~(4'b1111 << car_floor);

  assign here_hit   = (state_q == SELECT) && pending_q[car_floor];
  assign ack_expire = (state_q == WAIT_ACK) && !car_busy && ((ack_cnt_q + 32'd1) == ACK_TIMEOUT);
  assign arrived    = (state_q == TRAVEL) && !car_busy && (car_floor == tgt_q);

  // Nearest call above is the lowest set bit of above_mask
  always_comb begin
    up_found = 1'b1;
    up_fl    = 2'd0;
    casez (above_mask)
      4'b???1: up_fl = 2'd0;
      4'b??10: up_fl = 2'd1;
      4'b?100: up_fl = 2'd2;
      4'b1000: up_fl = 2'd3;
      default: up_found = 1'b0;
    endcase
  end

  // Nearest call below is the highest set bit of below_mask
  always_comb begin
    dn_found = 1'b1;
    dn_fl    = 2'd0;
    casez (below_mask)
      4'b1???: dn_fl = 2'd3;
      4'b01??: dn_fl = 2'd2;
      4'b001?: dn_fl = 2'd1;
      4'b0001: dn_fl = 2'd0;
      default: dn_found = 1'b0;
    endcase
  end

  // SCAN choice: keep the current sweep while it has work, otherwise reverse
  always_comb begin
    sel_fl = up_fl;
    sel_up = 1'b1;
    if (sweep_up_q) begin
      if (!up_found) begin
        sel_fl = dn_fl;
        sel_up = 1'b0;
      end
    end else begin
      if (dn_found) begin
        sel_fl = dn_fl;
        sel_up = 1'b0;
      end
    end
  end

  // Floors whose call is cleared this cycle; a park trip never clears a lamp
  always_comb begin
    clr_mask = 4'b0000;
    if (here_hit) begin
      clr_mask = clr_mask | (4'b0001 << car_floor);
    end
    if (arrived && !park_active) begin
      clr_mask = clr_mask | (4'b0001 << tgt_q);
    end
  end

  // Call latch and served pulse; a clear beats a simultaneous set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 4'b0000;
      served_q  <= 4'b0000;
    end else begin
      pending_q <= (pending_q | call_req) & ~clr_mask;
      served_q  <= clr_mask;
    end
  end

`ifdef PARK_EN
  logic [31:0] park_cnt_q;
  logic        park_q;
  logic        park_run;
  logic        park_go;

  assign park_run    = (state_q == IDLE) && (pending_q == 4'b0000) && !car_busy &&
                       (car_floor != PARK_FLOOR) && (call_req == 4'b0000);
  assign park_go     = park_run && ((park_cnt_q + 32'd1) == PARK_CYCLES);
  assign park_active = park_q;

  // Idle counter and park-trip flag; any call or leaving IDLE restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      park_cnt_q <= '0;
      park_q     <= 1'b0;
    end else begin
      if (park_run && !park_go) begin
        park_cnt_q <= park_cnt_q + 32'd1;
      end else begin
        park_cnt_q <= '0;
      end
      if (park_go) begin
        park_q <= 1'b1;
      end else if (ack_expire || arrived) begin
        park_q <= 1'b0;
      end
    end
  end
`else
  assign park_active = 1'b0;
`endif

  // Scheduler FSM; dest is frozen from SELECT until the car reports arrival or the ack times out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dest_q        <= DEST_NONE;
      tgt_q         <= 2'b00;
      sweep_dir_q   <= 2'b00;
      sweep_up_q    <= 1'b1;
      ack_cnt_q     <= '0;
      ack_timeout_q <= 1'b0;
      sched_busy_q  <= 1'b0;
    end else begin
      ack_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((pending_q != 4'b0000) && !car_busy) begin
            state_q      <= SELECT;
            sched_busy_q <= 1'b1;
          end
`ifdef PARK_EN
          else if (park_go) begin
            state_q      <= WAIT_ACK;
            dest_q       <= {1'b0, PARK_FLOOR};
            tgt_q        <= PARK_FLOOR;
            sweep_dir_q  <= (PARK_FLOOR > car_floor) ? 2'b01 : 2'b10;
            ack_cnt_q    <= '0;
            sched_busy_q <= 1'b1;
          end
`endif
        end
        SELECT: begin
          if (here_hit) begin
            state_q      <= IDLE;
            sched_busy_q <= 1'b0;
          end else begin
            state_q     <= WAIT_ACK;
            dest_q      <= {1'b0, sel_fl};
            tgt_q       <= sel_fl;
            sweep_up_q  <= sel_up;
            sweep_dir_q <= sel_up ? 2'b01 : 2'b10;
            ack_cnt_q   <= '0;
          end
        end
        WAIT_ACK: begin
          if (car_busy) begin
            ack_cnt_q <= '0;
            state_q   <= TRAVEL;
          end else if (ack_expire) begin
            ack_cnt_q     <= '0;
            ack_timeout_q <= 1'b1;
            dest_q        <= DEST_NONE;
            sweep_dir_q   <= 2'b00;
            state_q       <= IDLE;
            sched_busy_q  <= 1'b0;
          end else begin
            ack_cnt_q <= ack_cnt_q + 32'd1;
          end
        end
        TRAVEL: begin
          if (arrived) begin
            dest_q       <= DEST_NONE;
            sweep_dir_q  <= 2'b00;
            state_q      <= IDLE;
            sched_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          dest_q       <= DEST_NONE;
          sweep_dir_q  <= 2'b00;
          sched_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign dest        = dest_q;
  assign pending     = pending_q;
  assign sweep_dir   = sweep_dir_q;
  assign served      = served_q;
  assign ack_timeout = ack_timeout_q;
  assign sched_busy  = sched_busy_q;

endmodule
